// File: rtl/spi_transmitter.sv
// SPI mode-0 master for 3-byte ADXL362-style register access (instruction, address, data).
// Define SPI_LOOPBACK_EN to sample MOSI instead of the MISO pin for self-test.
module spi_transmitter #(
  parameter int CLK_DIV = 10,
  parameter int CS_GAP  = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       MISO,
  input  logic       ready,
  input  logic [7:0] inst,
  input  logic       rdh_wrl,
  input  logic [7:0] reg_addr,
  input  logic [7:0] dout,
  output logic       CSN,
  output logic       SCLK,
  output logic       MOSI,
  output logic [7:0] din,
  output logic       din_valid
);

  localparam int DW = $clog2(2 * CLK_DIV);
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [4:0]    bit_q, bit_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [23:0]   shift_q, shift_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    din_q, din_d;
  logic          is_read_q, is_read_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          valid_q, valid_d;
  logic          sample;

`ifdef SPI_LOOPBACK_EN
  assign sample = mosi_q;
`else
  assign sample = MISO;
`endif

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    gap_d     = gap_q;
    shift_d   = shift_q;
    rx_d      = rx_q;
    din_d     = din_q;
    is_read_d = is_read_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    valid_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ready) begin
          shift_d   = {inst, reg_addr, rdh_wrl ? 8'h00 : dout};
          is_read_d = rdh_wrl;
          mosi_d    = inst[7];
          div_d     = '0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        mosi_d = shift_q[23];
        if (div_q == DW'(CLK_DIV - 1)) begin
          div_d   = '0;
          bit_d   = '0;
          state_d = SHIFT;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      SHIFT: begin
        div_d = div_q + 1'b1;
        // Slave data is stable while SCLK is high, so capture at the rising edge
        if (div_q == DW'(CLK_DIV - 1)) begin
          sclk_d = 1'b1;
          rx_d   = {rx_q[6:0], sample};
        end
        if (div_q == DW'(2 * CLK_DIV - 1)) begin
          div_d  = '0;
          sclk_d = 1'b0;
          if (bit_q == 5'd23) begin
            mosi_d  = 1'b0;
            state_d = HOLD;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = {shift_q[22:0], 1'b0};
            mosi_d  = shift_q[22];
          end
        end
      end
      HOLD: begin
        if (div_q == DW'(CLK_DIV - 1)) begin
          div_d   = '0;
          gap_d   = '0;
          state_d = GAP;
          if (is_read_q) begin
            din_d   = rx_q;
            valid_d = 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GW'(CS_GAP - 1)) begin
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      gap_q     <= '0;
      shift_q   <= '0;
      rx_q      <= '0;
      din_q     <= '0;
      is_read_q <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      gap_q     <= gap_d;
      shift_q   <= shift_d;
      rx_q      <= rx_d;
      din_q     <= din_d;
      is_read_q <= is_read_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      valid_q   <= valid_d;
    end
  end

  // CSN drops combinationally in the ready cycle so the slave sees select one cycle early
  assign CSN = ~((state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD) ||
                 ((state_q == IDLE) && ready && !rst));

  assign SCLK      = sclk_q;
  assign MOSI      = mosi_q;
  assign din       = din_q;
  assign din_valid = valid_q;

endmodule

// File: tb/tb_spi_transmitter.sv
// Self-checking bench for spi_transmitter: a behavioural SPI slave drives MISO and
// records MOSI, and a byte-level model predicts frames, din and din_valid.
module tb_spi_transmitter;

  localparam int CLK_DIV    = 10;
  localparam int CS_GAP     = 20;
  localparam int TXN_CYCLES = 1 + CLK_DIV * 50;
`ifdef SPI_LOOPBACK_EN
  localparam bit LOOPBACK = 1'b1;
`else
  localparam bit LOOPBACK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       MISO;
  logic       ready;
  logic [7:0] inst;
  logic       rdh_wrl;
  logic [7:0] reg_addr;
  logic [7:0] dout;
  logic       CSN;
  logic       SCLK;
  logic       MOSI;
  logic [7:0] din;
  logic       din_valid;

  int         assertCount = 0;
  int         failCount   = 0;
  logic [7:0] expDin;

  always #5 clk = ~clk;

  spi_transmitter #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .rst(rst), .MISO(MISO), .ready(ready), .inst(inst),
    .rdh_wrl(rdh_wrl), .reg_addr(reg_addr), .dout(dout), .CSN(CSN),
    .SCLK(SCLK), .MOSI(MOSI), .din(din), .din_valid(din_valid)
  );

  // One comparison: counts it, and on mismatch counts a failure and reports it
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Runs one transaction end to end, acting as the slave and monitoring the pins.
  // abortBit > 0 asserts rst after that many SCLK rises; pokeReady pulses ready mid-SHIFT.
  task automatic applyStimulus(input bit isRead, input logic [7:0] instB,
                               input logic [7:0] addrB, input logic [7:0] dataB,
                               input logic [7:0] respB, input int abortBit,
                               input bit pokeReady);
    logic [23:0] expFrame;
    logic [23:0] slaveWord;
    logic [23:0] mosiCap;
    int          rises, falls, lowCycles, validLow, gapLow, gapValid;
    bit          prevSclk, done, pokeLive;
    expFrame  = {instB, addrB, isRead ? 8'h00 : dataB};
    slaveWord = {16'($urandom), respB};
    mosiCap   = '0;
    rises     = 0;
    falls     = 0;
    lowCycles = 1;
    validLow  = 0;
    prevSclk  = 1'b0;
    done      = 1'b0;
    pokeLive  = 1'b0;

    @(negedge clk);
    MISO     = slaveWord[23];
    inst     = instB;
    reg_addr = addrB;
    dout     = dataB;
    rdh_wrl  = isRead;
    ready    = 1'b1;
    #1 checkOutput("csn_falls_with_ready", 32'(CSN), 32'd0);

    @(negedge clk);
    ready    = 1'b0;
    inst     = 8'($urandom);
    reg_addr = 8'($urandom);
    dout     = 8'($urandom);
    rdh_wrl  = 1'($urandom);

    for (int c = 0; c < 4 * TXN_CYCLES && !done; c++) begin
      if (CSN) begin
        done = 1'b1;
      end else begin
        lowCycles++;
        if (pokeLive) begin
          ready    = 1'b0;
          pokeLive = 1'b0;
        end
        if (din_valid) validLow++;
        if (SCLK && !prevSclk) begin
          rises++;
          mosiCap = {mosiCap[22:0], MOSI};
          if (pokeReady && rises == 5) begin
            ready    = 1'b1;
            pokeLive = 1'b1;
            inst     = 8'hFF;
            rdh_wrl  = 1'b0;
          end
        end
        if (!SCLK && prevSclk) begin
          falls++;
          if (falls < 24) MISO = slaveWord[23 - falls];
        end
        prevSclk = SCLK;
        if (abortBit > 0 && rises == abortBit) begin
          rst = 1'b1;
          @(posedge clk);
          #1;
          checkOutput("abort_csn_high", 32'(CSN), 32'd1);
          checkOutput("abort_sclk_low", 32'(SCLK), 32'd0);
          checkOutput("abort_mosi_low", 32'(MOSI), 32'd0);
          checkOutput("abort_no_valid", 32'(din_valid), 32'd0);
          checkOutput("abort_din_cleared", 32'(din), 32'd0);
          @(negedge clk);
          rst    = 1'b0;
          expDin = 8'h00;
          return;
        end
        @(negedge clk);
      end
    end

    checkOutput("csn_rise_timeout", 32'(done), 32'd1);
    checkOutput("din_valid_at_csn_rise", 32'(din_valid), 32'(isRead));
    if (isRead) expDin = LOOPBACK ? 8'h00 : respB;
    checkOutput("din_value", 32'(din), 32'(expDin));
    checkOutput("sclk_rise_count", 32'(rises), 32'd24);
    checkOutput("mosi_frame", 32'(mosiCap), 32'(expFrame));
    checkOutput("no_valid_while_selected", 32'(validLow), 32'd0);
    checkOutput("txn_length_in_range",
                32'((lowCycles >= TXN_CYCLES - 1) && (lowCycles <= TXN_CYCLES + 1)), 32'd1);
    checkOutput("mosi_low_after_txn", 32'(MOSI), 32'd0);
    checkOutput("sclk_low_after_txn", 32'(SCLK), 32'd0);

    // ready pulsed inside the gap must be dropped, not started later
    gapLow   = 0;
    gapValid = 0;
    for (int g = 1; g < CS_GAP + 3; g++) begin
      @(negedge clk);
      if (g == 3) ready = 1'b1;
      if (g == 4) ready = 1'b0;
      #1;
      if (!CSN) gapLow++;
      if (din_valid) gapValid++;
    end
    checkOutput("csn_high_through_gap", 32'(gapLow), 32'd0);
    checkOutput("din_valid_single_cycle", 32'(gapValid), 32'd0);
    checkOutput("din_held_after_gap", 32'(din), 32'(expDin));
  endtask

  initial begin
    bit         rndRead;
    logic [7:0] rndAddr;
    logic [7:0] rndData;
    logic [7:0] rndResp;
    rst      = 1'b1;
    ready    = 1'b0;
    MISO     = 1'b0;
    inst     = 8'h00;
    reg_addr = 8'h00;
    dout     = 8'h00;
    rdh_wrl  = 1'b0;
    expDin   = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_csn", 32'(CSN), 32'd1);
    checkOutput("reset_sclk", 32'(SCLK), 32'd0);
    checkOutput("reset_mosi", 32'(MOSI), 32'd0);
    checkOutput("reset_din", 32'(din), 32'd0);
    checkOutput("reset_din_valid", 32'(din_valid), 32'd0);
    rst = 1'b0;
    $display("[TB] reset released");

    applyStimulus(1'b0, 8'h0A, 8'h2D, 8'h0A, 8'h00, 0, 1'b0);
    applyStimulus(1'b1, 8'h0B, 8'h08, 8'h77, 8'hA5, 0, 1'b0);
    applyStimulus(1'b1, 8'h0B, 8'h0E, 8'h00, 8'h5A, 0, 1'b1);
    applyStimulus(1'b0, 8'h0A, 8'h1F, 8'hC3, 8'h00, 0, 1'b0);
    applyStimulus(1'b1, 8'h0B, 8'h20, 8'h00, 8'h96, 10, 1'b0);
    applyStimulus(1'b1, 8'h0B, 8'h09, 8'h00, 8'h3C, 0, 1'b0);
    $display("[TB] directed transactions done");

    for (int i = 0; i < 6; i++) begin
      rndRead = 1'($urandom);
      rndAddr = 8'($urandom);
      rndData = 8'($urandom);
      rndResp = 8'($urandom);
      applyStimulus(rndRead, rndRead ? 8'h0B : 8'h0A, rndAddr, rndData, rndResp, 0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
